pulse_burst_tx: RTL and testbench

- Pulse-burst transmitter: on a start request it emits a programmable number of clean, fixed-width pulses on one output pin.
- It is the sending end for the team's synchronised edge-counting receivers: each emitted pulse produces exactly one rising edge for a receiver to count.
- Packaged as a standard 8-in/8-out user module. Busy, done and remaining-count outputs let a bench or a downstream counter cross-check totals.

---
 rtl/pulse_burst_tx.sv | 131 +++++++++++++
 tb/tb_pulse_burst_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_tx.sv
// Pulse-burst transmitter: a start edge launches N fixed-width pulses
// on io_out[0], with busy/done/remaining/state status alongside.
module pulse_burst_tx #(
    parameter int HIGH_CYCLES = 2,
    parameter int LOW_CYCLES  = 2,
    parameter int SLOW_MULT   = 4
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HIGH = 2'b01,
        S_LOW  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [7:0] H_LAST   = 8'(HIGH_CYCLES - 1);
    localparam logic [7:0] L_LAST   = 8'(LOW_CYCLES - 1);
    localparam logic [7:0] H_LAST_S = 8'(HIGH_CYCLES * SLOW_MULT - 1);
    localparam logic [7:0] L_LAST_S = 8'(LOW_CYCLES * SLOW_MULT - 1);

    logic       clk;
    logic       rst_n;
    logic       start_s1;
    logic       start_s2;
    logic       start_prev;
    logic       abort_s1;
    logic       abort_s2;
    logic       start_edge;
    state_t     state;
    logic [7:0] phase;
    logic [3:0] rem;
    logic       slow_q;
    logic [7:0] h_last;
    logic [7:0] l_last;
    logic       h_end;
    logic       l_end;
    logic       pulse_q;
    logic       busy_q;
    logic       done_q;
    logic [2:0] rem_q;
    logic [1:0] code_q;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_prev <= 1'b0;
            abort_s1   <= 1'b0;
            abort_s2   <= 1'b0;
        end else begin
            start_s1   <= io_in[2];
            start_s2   <= start_s1;
            start_prev <= start_s2;
            abort_s1   <= io_in[6];
            abort_s2   <= abort_s1;
        end
    end

    assign start_edge = start_s2 & ~start_prev;
    assign h_last     = slow_q ? H_LAST_S : H_LAST;
    assign l_last     = slow_q ? L_LAST_S : L_LAST;
    assign h_end      = (phase == h_last);
    assign l_end      = (phase == l_last);

    // Outputs are registered images of the current state, one clock behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            phase   <= 8'd0;
            rem     <= 4'd0;
            slow_q  <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= 3'd0;
            code_q  <= 2'b00;
        end else begin
            pulse_q <= (state == S_HIGH);
            busy_q  <= (state == S_HIGH) || (state == S_LOW);
            done_q  <= (state == S_DONE);
            rem_q   <= rem[2:0];
            code_q  <= state;
            phase   <= phase + 8'd1;
            unique case (state)
                S_IDLE: begin
                    phase <= 8'd0;
                    if (start_edge && !abort_s2) begin
                        rem    <= (io_in[5:3] == 3'd0) ? 4'd8
                                                       : {1'b0, io_in[5:3]};
                        slow_q <= io_in[7];
                        state  <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (abort_s2) begin
                        state <= S_IDLE;
                        rem   <= 4'd0;
                        phase <= 8'd0;
                    end else if (h_end) begin
                        rem   <= rem - 4'd1;
                        state <= S_LOW;
                        phase <= 8'd0;
                    end
                end
                S_LOW: begin
                    if (abort_s2) begin
                        state <= S_IDLE;
                        rem   <= 4'd0;
                        phase <= 8'd0;
                    end else if (l_end) begin
                        state <= (rem != 4'd0) ? S_HIGH : S_DONE;
                        phase <= 8'd0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    phase <= 8'd0;
                end
            endcase
        end
    end

    assign io_out = {code_q, rem_q, done_q, busy_q, pulse_q};

endmodule

// File: tb/tb_pulse_burst_tx.sv
// Scoreboard bench for pulse_burst_tx: stimulus queues expected bursts,
// a negedge monitor measures each burst and compares.
module tb_pulse_burst_tx;

    typedef struct {
        int n;
        int hc;
        int lc;
        bit ab;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       slow  = 1'b0;
    logic [2:0] n_in  = 3'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {slow, abort, n_in, start, rst_n, clk};

    pulse_burst_tx dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    logic       pulse;
    logic       busy;
    logic       done;
    logic [2:0] rem_o;
    logic [1:0] code;
    assign pulse = io_out[0];
    assign busy  = io_out[1];
    assign done  = io_out[2];
    assign rem_o = io_out[5:3];
    assign code  = io_out[7:6];

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    bit   mon_en = 1'b1;
    int   bursts_done = 0;

    function automatic void chk(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endfunction

    function automatic void push(int nn, int hc, int lc, bit ab);
        exp_t e;
        e.n  = nn;
        e.hc = hc;
        e.lc = lc;
        e.ab = ab;
        exp_q.push_back(e);
    endfunction

    // Independent edge-counting receiver on the pulse line
    logic r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
    int   rx_cnt = 0;
    always @(posedge clk) begin
        r1 <= pulse;
        r2 <= r1;
        r3 <= r2;
        if (r2 && !r3) rx_cnt <= rx_cnt + 1;
    end

    // Monitor
    bit   in_b = 1'b0;
    bit   lvl;
    bit   unexp;
    int   run, blen, npls, nlo, hi_w, lo_w, rem_w;
    exp_t cur;

    always @(negedge clk) begin
        if (!mon_en) begin
            in_b = 1'b0;
        end else if (!in_b) begin
            if (busy) begin
                in_b  = 1'b1;
                lvl   = 1'b1;
                run   = 1;
                blen  = 1;
                npls  = 1;
                nlo   = 0;
                unexp = (exp_q.size() == 0);
                if (unexp) begin
                    chk("unexpected_burst", 1, 0);
                    cur.n  = 0;
                    cur.hc = 0;
                    cur.lc = 0;
                    cur.ab = 1'b0;
                end else begin
                    cur = exp_q[0];
                end
                hi_w  = cur.hc;
                lo_w  = cur.lc;
                rem_w = -1;
                if (!unexp && !cur.ab)
                    chk("rem_first_pulse", rem_o, cur.n & 7);
            end
        end else if (busy) begin
            blen++;
            if (pulse == lvl) begin
                run++;
            end else begin
                if (lvl) begin
                    if (run != cur.hc && hi_w == cur.hc) hi_w = run;
                end else begin
                    nlo++;
                    if (run != cur.lc && lo_w == cur.lc) lo_w = run;
                end
                lvl = pulse;
                run = 1;
                if (pulse) begin
                    npls++;
                    if (int'(rem_o) != ((cur.n - npls + 1) & 7) && rem_w < 0)
                        rem_w = npls;
                end
            end
        end else begin
            in_b = 1'b0;
            if (!lvl) begin
                nlo++;
                if (run != cur.lc && lo_w == cur.lc) lo_w = run;
            end
            if (!unexp) begin
                cur = exp_q.pop_front();
                chk("end_done_strobe", done, cur.ab ? 0 : 1);
                chk("pulse_count", npls, cur.n);
                if (!cur.ab) begin
                    chk("burst_len", blen + 1,
                        cur.n * (cur.hc + cur.lc) + 1);
                    chk("hi_width", hi_w, cur.hc);
                    chk("lo_width", lo_w, cur.lc);
                    chk("lo_count", nlo, cur.n);
                    chk("rem_seq_bad_pulse", rem_w, -1);
                end else begin
                    chk("abort_end_state", code, 0);
                    chk("abort_end_rem", rem_o, 0);
                end
            end
            bursts_done++;
        end
    end

    task automatic wait_end(input int limit);
        int  b0;
        bit  hit;
        b0  = bursts_done;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(posedge clk);
            if (bursts_done != b0) hit = 1'b1;
        end
        if (!hit) chk("burst_end_timeout", 0, 1);
    endtask

    task automatic burst(input int nn, input bit sl);
        @(negedge clk);
        n_in = 3'(nn);
        slow = sl;
        push(nn, sl ? 8 : 2, sl ? 8 : 2, 1'b0);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cnt;
        bit prevp;
        int base;

        repeat (3) @(negedge clk);
        chk("reset_out", io_out, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", io_out, 0);

        // N=3, latency to first pulse
        @(negedge clk);
        n_in = 3'd3;
        slow = 1'b0;
        push(3, 2, 2, 1'b0);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("latency_pre", pulse, 0);
        @(posedge clk);
        #1 chk("latency_hit", pulse, 1);
        @(negedge clk);
        start = 1'b0;
        wait_end(100);

        // N=0 slow; N and slow changed mid-burst
        @(negedge clk);
        n_in = 3'd0;
        slow = 1'b1;
        push(8, 8, 8, 1'b0);
        start = 1'b1;
        repeat (20) @(negedge clk);
        n_in  = 3'd3;
        slow  = 1'b0;
        start = 1'b0;
        wait_end(300);

        // Re-pulsed start mid-burst, then held high
        @(negedge clk);
        n_in = 3'd3;
        push(3, 2, 2, 1'b0);
        start = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        wait_end(100);
        repeat (20) @(negedge clk);
        chk("held_start_busy", busy, 0);
        chk("held_start_state", code, 0);
        start = 1'b0;
        repeat (4) @(negedge clk);

        // Abort during 2nd pulse
        @(negedge clk);
        n_in = 3'd3;
        push(2, 2, 2, 1'b1);
        start = 1'b1;
        cnt   = 0;
        prevp = 1'b0;
        for (int i = 0; i < 50 && cnt < 2; i++) begin
            @(negedge clk);
            if (i == 3) start = 1'b0;
            if (pulse && !prevp) cnt++;
            prevp = pulse;
        end
        start = 1'b0;
        chk("abort_reach_p2", cnt, 2);
        abort = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_pulse_low", pulse, 0);
        chk("abort_code", code, 0);
        chk("abort_rem", rem_o, 0);
        chk("abort_busy", busy, 0);
        wait_end(10);

        // Start edge while abort held is ignored
        @(negedge clk);
        start = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_blocks_start", code, 0);

        // Loopback receiver, N=1..8
        for (int k = 1; k <= 8; k++) begin
            base = rx_cnt;
            burst(k, 1'b0);
            wait_end(100);
            repeat (5) @(negedge clk);
            chk($sformatf("rx_count_n%0d", k), rx_cnt - base, k);
        end

        // Asynchronous reset mid-burst
        @(negedge clk);
        #2 mon_en = 1'b0;
        n_in  = 3'd5;
        slow  = 1'b0;
        start = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("reset_async_out", io_out, 0);
        @(posedge clk);
        #1 chk("reset_hold_out", io_out, 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_idle", io_out, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
